// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory and decoder-side signals of the fetch unit.
// master (fetch unit): drives imem_req/imem_addr, instr/instr_pc/instr_valid, halted, fault;
//                      receives imem_ready/imem_rvalid/imem_rdata, instr_ready, redirect/redirect_pc, halt.
// slave (environment): the mirror image.
interface instr_fetch_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        halt;
   logic        halted;
   logic        fault;
   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fault,
      input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
   );
   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fault,
      output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with redirect, halt and response squashing.
// Ports: clk, reset (sync, active-high); io_bus (instr_fetch_if.master) carries the memory
// request/response, the decoder handshake, redirect/halt controls and halted/fault status.
// Build option: INSTR_FETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault; otherwise
// the low two target bits are dropped and fault reads 0.
module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h2000,
   parameter logic [63:0] PC_STEP  = 64'd4
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_if.master  io_bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} state_t;
   state_t      r_state, w_next;
   logic [63:0] r_pc, r_instr_pc, w_target;
   logic [31:0] r_instr;
   logic        r_valid, r_squash;
   logic        w_bad, w_acc, w_pend, w_live, w_redir, w_stop, w_take;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic r_fault;
   assign w_target = io_bus.redirect_pc;
   assign w_bad    = |io_bus.redirect_pc[1:0];
   always_ff @(posedge clk)
      if (reset) r_fault <= 1'b0;
      else if (w_live && io_bus.redirect && w_bad) r_fault <= 1'b1;
   assign io_bus.fault = r_fault;
`else
   logic w_unused_lsb;
   assign w_target     = {io_bus.redirect_pc[63:2], 2'b00};
   assign w_bad        = 1'b0;
   assign w_unused_lsb = ^io_bus.redirect_pc[1:0];
   assign io_bus.fault = 1'b0;
`endif
   assign w_live  = r_state != HALTED;
   assign w_acc   = io_bus.imem_req && io_bus.imem_ready;
   // A response will still arrive after this edge that nobody wants any more.
   assign w_pend  = w_acc || (r_state == WAIT && !io_bus.imem_rvalid) || (r_squash && !io_bus.imem_rvalid);
   assign w_redir = w_live && io_bus.redirect && !w_bad;
   // Halt, or a faulting redirect, both stop fetching; redirect outranks halt.
   assign w_stop  = w_live && (io_bus.redirect ? w_bad : io_bus.halt);
   assign w_take  = r_state == WAIT && io_bus.imem_rvalid && !r_squash && !w_redir && !w_stop;
   // WAIT with squash set only occurs while a halt drains its outstanding response.
   always_comb begin
      w_next = r_state;
      if (w_redir) w_next = REQ;
      else if (w_stop) w_next = w_pend ? WAIT : HALTED;
      else
         case (r_state)
            IDLE:    w_next = REQ;
            REQ:     w_next = w_acc ? WAIT : REQ;
            WAIT:    w_next = !io_bus.imem_rvalid ? WAIT : r_squash ? HALTED : HOLD;
            HOLD:    w_next = (r_valid && io_bus.instr_ready) ? REQ : HOLD;
            default: w_next = HALTED;
         endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_squash   <= w_pend;
      end else begin
         r_state  <= w_next;
         r_squash <= (w_redir || w_stop) ? w_pend : r_squash && !io_bus.imem_rvalid;
         r_valid  <= (w_redir || w_stop) ? 1'b0 : w_take ? 1'b1 : r_valid && !io_bus.instr_ready;
         if (w_redir) r_pc <= w_target;
         else if (w_take) r_pc <= r_pc + PC_STEP;
         if (w_take) begin
            r_instr    <= io_bus.imem_rdata;
            r_instr_pc <= r_pc;
         end
      end
   end
   // While an unwanted response is still owed, no new request is exposed to memory.
   assign io_bus.imem_req    = r_state == REQ && !r_squash;
   assign io_bus.imem_addr   = r_pc;
   assign io_bus.instr       = r_instr;
   assign io_bus.instr_pc    = r_instr_pc;
   assign io_bus.instr_valid = r_valid;
   assign io_bus.halted      = r_state == HALTED;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch with a memory/decoder model.
module tb_instr_fetch;
   localparam logic [63:0] RST_PC = 64'h2000;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   instr_fetch_if bus();
   instr_fetch #(.RESET_PC(RST_PC), .PC_STEP(64'd4)) dut (.clk(clk), .reset(reset), .io_bus(bus));
   int checks = 0, errors = 0;
   int cyc = 0, acc_cnt = 0, cons_cnt = 0, acc_cyc = 0, prev_acc_cyc = 0;
   int lat_min = 0, lat_max = 0, m_cnt = 0;
   bit m_busy = 0, force_data = 0, rdy_rand = 0, dec_rand = 0, dec_rdy = 1, model_halted = 0, saw_dead = 0;
   logic [63:0] exp_pc = RST_PC, acc_addr = '0, cons_pc = '0;
   logic [31:0] m_data = '0, cons_instr = '0;
   logic [63:0] cons_q[$];
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
   endfunction
   // Memory, decoder and scoreboard: everything is decided at the falling edge for the next rising edge.
   always @(negedge clk) begin
      cyc++;
      bus.imem_rvalid = 1'b0;
      if (m_busy) begin
         if (m_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = m_data;
            m_busy = 0;
         end else m_cnt--;
      end
      bus.imem_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.instr_ready = dec_rand ? 1'($urandom_range(0, 1)) : dec_rdy;
      if (bus.instr_valid && bus.instr === 32'hDEADBEEF) saw_dead = 1;
      if (reset) begin
         exp_pc = RST_PC;
         model_halted = 0;
      end else begin
         if (bus.imem_req && bus.imem_ready) begin
            checks++;
            if (m_busy || model_halted || bus.imem_addr !== exp_pc) begin
               errors++;
               $display("FAIL fetch_addr got %h (busy %0d halted %0d) want %h", bus.imem_addr, m_busy, model_halted, exp_pc);
            end
         end
         if (bus.instr_valid && bus.instr_ready && !bus.redirect && !bus.halt) begin
            checks++;
            if (model_halted || bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL consume got pc %h instr %h want pc %h instr %h", bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
            end
            cons_pc = bus.instr_pc;
            cons_instr = bus.instr;
            cons_q.push_back(bus.instr_pc);
            cons_cnt++;
            exp_pc = exp_pc + 64'd4;
         end
         if (!model_halted && bus.redirect) begin
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) model_halted = 1;
            else exp_pc = bus.redirect_pc;
`else
            exp_pc = bus.redirect_pc & ~64'h3;
`endif
         end else if (bus.halt) model_halted = 1;
      end
      if (bus.imem_req && bus.imem_ready) begin
         m_busy = 1;
         m_cnt = $urandom_range(lat_min, lat_max);
         m_data = force_data ? 32'hDEADBEEF : mem_word(bus.imem_addr);
         force_data = 0;
         acc_addr = bus.imem_addr;
         acc_cnt++;
         prev_acc_cyc = acc_cyc;
         acc_cyc = cyc;
      end
   end
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic wait_cons(input int n);
      int t0 = cons_cnt;
      int k = 0;
      while (cons_cnt < t0 + n && k < 300) begin step(); k++; end
      if (cons_cnt < t0 + n) begin checks++; errors++; $display("FAIL wait_consume got %0d want %0d", cons_cnt - t0, n); end
   endtask
   task automatic wait_acc();
      int t0 = acc_cnt;
      int k = 0;
      while (acc_cnt == t0 && k < 300) begin step(); k++; end
      if (acc_cnt == t0) begin checks++; errors++; $display("FAIL wait_accept got 0 want 1"); end
   endtask
   task automatic wait_valid();
      int k = 0;
      while (bus.instr_valid !== 1'b1 && k < 300) begin step(); k++; end
      if (bus.instr_valid !== 1'b1) begin checks++; errors++; $display("FAIL wait_valid got 0 want 1"); end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.halt = 1'b0;
      bus.redirect_pc = '0;
      step();
      step();
      checks += 7;
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", bus.imem_req); end
      if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, RST_PC); end
      if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instr); end
      if (bus.instr_pc !== 64'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", bus.instr_pc); end
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.instr_valid); end
      if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
      if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", bus.fault); end
      reset = 1'b0;
   endtask
   task automatic test_sequential();
      dec_rdy = 1;
      wait_cons(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cons_q.size() < 3 || cons_q[cons_q.size() - 3 + i] !== RST_PC + 64'(4 * i)) begin
            errors++;
            $display("FAIL seq_pc%0d got %h want %h", i, cons_q.size() < 3 ? 64'hx : cons_q[cons_q.size() - 3 + i], RST_PC + 64'(4 * i));
         end
      end
      checks++;
      if (acc_cyc - prev_acc_cyc != 3) begin errors++; $display("FAIL issue_interval got %0d want 3", acc_cyc - prev_acc_cyc); end
   endtask
   task automatic test_stall();
      dec_rdy = 0;
      wait_valid();
      repeat (5) begin
         step();
         checks += 4;
         if (bus.instr !== mem_word(exp_pc)) begin errors++; $display("FAIL stall_instr got %h want %h", bus.instr, mem_word(exp_pc)); end
         if (bus.instr_pc !== exp_pc) begin errors++; $display("FAIL stall_pc got %h want %h", bus.instr_pc, exp_pc); end
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %0b want 0", bus.imem_req); end
         if (bus.imem_addr !== exp_pc + 64'd4) begin errors++; $display("FAIL stall_addr got %h want %h", bus.imem_addr, exp_pc + 64'd4); end
      end
      dec_rdy = 1;
   endtask
   task automatic test_redirect_wait();
      lat_min = 2;
      lat_max = 2;
      force_data = 1;
      wait_acc();
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'h3000;
      step();
      bus.redirect = 1'b0;
      lat_min = 0;
      lat_max = 0;
      wait_acc();
      checks++;
      if (acc_addr !== 64'h3000) begin errors++; $display("FAIL redirect_addr got %h want 3000", acc_addr); end
      wait_cons(1);
      checks += 3;
      if (cons_pc !== 64'h3000) begin errors++; $display("FAIL redirect_pc got %h want 3000", cons_pc); end
      if (cons_instr !== mem_word(64'h3000)) begin errors++; $display("FAIL redirect_instr got %h want %h", cons_instr, mem_word(64'h3000)); end
      if (saw_dead !== 1'b0) begin errors++; $display("FAIL squash_deadbeef got %0b want 0", saw_dead); end
   endtask
   task automatic test_redirect_halt();
      dec_rdy = 0;
      wait_valid();
      bus.redirect = 1'b1;
      bus.halt = 1'b1;
      bus.redirect_pc = 64'h4000;
      step();
      bus.redirect = 1'b0;
      bus.halt = 1'b0;
      checks += 2;
      if (bus.halted !== 1'b0) begin errors++; $display("FAIL both_halted got %0b want 0", bus.halted); end
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL both_valid got %0b want 0", bus.instr_valid); end
      dec_rdy = 1;
      wait_cons(1);
      checks++;
      if (cons_pc !== 64'h4000) begin errors++; $display("FAIL both_pc got %h want 4000", cons_pc); end
   endtask
   task automatic test_wrap();
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      wait_cons(2);
      checks += 2;
      if (cons_q[cons_q.size() - 2] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h want fffffffffffffffc", cons_q[cons_q.size() - 2]); end
      if (cons_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc1 got %h want 0", cons_pc); end
   endtask
   task automatic test_reset_wait();
      lat_min = 3;
      lat_max = 3;
      wait_acc();
      reset = 1'b1;
      step();
      reset = 1'b0;
      lat_min = 0;
      lat_max = 0;
      wait_cons(1);
      checks += 2;
      if (cons_pc !== RST_PC) begin errors++; $display("FAIL rstwait_pc got %h want %h", cons_pc, RST_PC); end
      if (cons_instr !== mem_word(RST_PC)) begin errors++; $display("FAIL rstwait_instr got %h want %h", cons_instr, mem_word(RST_PC)); end
   endtask
   task automatic test_random();
      int c0 = cons_cnt;
      rdy_rand = 1;
      dec_rand = 1;
      lat_min = 0;
      lat_max = 3;
      repeat (400) begin
         bus.redirect = ($urandom_range(0, 19) == 0);
         bus.redirect_pc = {$urandom, $urandom} & ~64'h3;
         step();
      end
      bus.redirect = 1'b0;
      rdy_rand = 0;
      dec_rand = 0;
      lat_min = 0;
      lat_max = 0;
      checks++;
      if (cons_cnt - c0 < 20) begin errors++; $display("FAIL random_progress got %0d want >=20", cons_cnt - c0); end
   endtask
   task automatic test_halt();
      dec_rdy = 0;
      wait_valid();
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      checks += 3;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %0b want 0", bus.instr_valid); end
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %0b want 1", bus.halted); end
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %0b want 0", bus.imem_req); end
      repeat (5) begin
         step();
         checks += 3;
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halted_req got %0b want 0", bus.imem_req); end
         if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted_state got %0b want 1", bus.halted); end
         if (bus.imem_addr !== exp_pc + 64'd4) begin errors++; $display("FAIL halted_pc got %h want %h", bus.imem_addr, exp_pc + 64'd4); end
      end
      dec_rdy = 1;
   endtask
   task automatic test_fault();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      dec_rdy = 0;
      wait_valid();
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'h3002;
      step();
      bus.redirect = 1'b0;
      dec_rdy = 1;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      checks += 2;
      if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %0b want 1", bus.fault); end
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL fault_halted got %0b want 1", bus.halted); end
      repeat (5) begin
         step();
         checks++;
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fault_req got %0b want 0", bus.imem_req); end
      end
`else
      checks++;
      if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_flag got %0b want 0", bus.fault); end
      wait_acc();
      checks++;
      if (acc_addr !== 64'h3000) begin errors++; $display("FAIL align_addr got %h want 3000", acc_addr); end
`endif
   endtask
   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_halt();
      test_wrap();
      test_reset_wait();
      test_random();
      test_halt();
      test_fault();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h2000, PC loaded on reset.
REQ-002 Parameter PC_STEP, 4, byte increment between sequential instructions.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  64  fetch byte address.
REQ-007 imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-008 imem_rvalid  input  1  response data valid, one cycle per accepted request.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr  output  32  instruction word to the decoder.
REQ-011 instr_pc  output  64  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc valid.
REQ-013 instr_ready  input  1  decoder consumes when instr_valid && instr_ready.
REQ-014 redirect  input  1  taken branch; driven from decoder pc_src qualified by execute.
REQ-015 redirect_pc  input  64  branch target.
REQ-016 halt  input  1  decoder halt; stops fetching.
REQ-017 halted  output  1  fetch stopped.
REQ-018 fault  output  1  misaligned target detected (Configuration only).

Function
REQ-019 States: IDLE, REQ, WAIT, HOLD, HALTED; at most one request outstanding.
REQ-020 IDLE -> REQ next cycle; REQ drives imem_req=1, imem_addr=pc.
REQ-021 REQ: on imem_ready go WAIT; imem_addr and imem_req hold stable until accepted.
REQ-022 WAIT: on imem_rvalid latch imem_rdata into instr, pc into instr_pc, set instr_valid, go HOLD; pc <= pc + PC_STEP (64-bit wrap, no carry-out).
REQ-023 HOLD: instr, instr_pc stable while instr_valid && !instr_ready; on handshake clear instr_valid, go REQ same edge (min issue interval 3 cycles, zero-wait memory).
REQ-024 redirect in any non-HALTED state: pc <= redirect_pc, instr_valid <= 0 next edge, state -> REQ; redirect outranks halt and handshake in same cycle.
REQ-025 redirect in WAIT: response still arriving is discarded via squash flag; no new request until it returns; then REQ at redirect_pc.
REQ-026 redirect in REQ before acceptance: imem_addr switches to redirect_pc next cycle; no discard needed.
REQ-027 halt (no redirect): instr_valid <= 0, pending response squashed, state -> HALTED after any outstanding response drains; halted=1 in HALTED.
REQ-028 HALTED: imem_req=0, instr_valid=0, pc frozen; exited only by reset.
REQ-029 imem_rvalid outside WAIT is ignored.

Reset
REQ-030 reset: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, squash=0.
REQ-031 reset mid-WAIT: later imem_rvalid for the aborted request is ignored (squash set for one outstanding response if reset hit in WAIT).

Configuration
REQ-032 Macro INSTR_FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fault=1 (sticky until reset), state -> HALTED, no request at bad address.
REQ-033 Macro undefined: fault tied 0, redirect_pc[1:0] forced to 2'b00 before load.

Verification
REQ-034 Reset, zero-wait memory, instr_ready=1 -> addresses 0x2000,0x2004,0x2008 fetched in order, instr_pc matches.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0, no pc advance.
REQ-036 redirect to 0x3000 during WAIT, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never valid; next request addr 0x3000.
REQ-037 redirect and halt same cycle -> redirect taken, halted stays 0.
REQ-038 halt in HOLD -> instr_valid=0 next cycle, halted=1, imem_req=0 thereafter.
REQ-039 INSTR_FETCH_ALIGN_CHECK_EN defined, redirect to 0x3002 -> fault=1, halted=1, no request to 0x3002; undefined -> request to 0x3000.
